// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the cpu run-control sequencer: state encoding,
// default halt opcode and the CLEAR hold-counter width.
package cpu_sequencer_pkg;

  localparam int          CLR_CNT_W    = 4;
  localparam logic [15:0] HALT_INS_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_IDLE    = 3'd1,
    S_FETCH   = 3'd2,
    S_EXEC_LO = 3'd3,
    S_EXEC_HI = 3'd4,
    S_HALT    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/cpu_sequencer_step_counter.sv
// Generic enable/clear up-counter; wraps naturally at 2**W.
module step_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i)     cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/run-control sequencer for the single-cycle cpu: fetches one word per
// instruction, pulses cpu_clk low once, and handles run/step/breakpoint/halt.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter logic [15:0] HALT_INS     = HALT_INS_DEF
) (
  input  logic        clk,
  input  logic        _clear,
  input  logic        run,
  input  logic        step,
  input  logic        bkpt_en,
  input  logic [15:0] bkpt_addr,
  input  logic [15:0] pc,
  output logic        cpu_clk,
  output logic        cpu_clear,
  output logic [15:0] cpu_ins,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        stopped,
  output logic        halted,
  output logic [15:0] steps
);

  localparam logic [CLR_CNT_W-1:0] CLR_INIT = CLR_CNT_W'(CLEAR_CYCLES);

  seq_state_e           state_q, state_d;
  logic [CLR_CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic                 oneshot_q, oneshot_d;
  logic [15:0]          ins_q, ins_d;
  logic [15:0]          addr_q, addr_d;
  logic                 cpu_clk_q, cpu_clear_q, mem_req_q, stopped_q, halted_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    oneshot_d = oneshot_q;
    ins_d     = ins_q;
    addr_d    = addr_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q > CLR_CNT_W'(1)) clr_cnt_d = clr_cnt_q - 1'b1;
        else                           state_d   = S_IDLE;
      end
      S_IDLE: begin
        if (run) begin
          state_d   = S_FETCH;
          oneshot_d = 1'b0;
        end else if (step) begin
          state_d   = S_FETCH;
          oneshot_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          ins_d   = mem_data;
          state_d = (mem_data == HALT_INS) ? S_HALT : S_EXEC_LO;
        end
      end
      S_EXEC_LO: state_d = S_EXEC_HI;
      S_EXEC_HI: begin
        // pc here is already the post-writeback value, so the breakpoint
        // can never block the first instruction issued from IDLE.
        if (oneshot_q || !run)                  state_d = S_IDLE;
        else if (bkpt_en && (pc == bkpt_addr))  state_d = S_IDLE;
        else                                    state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_CLEAR;
    endcase
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) addr_d = pc;
  end

  always_ff @(posedge clk) begin
    if (!_clear) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= CLR_INIT;
      oneshot_q   <= 1'b0;
      ins_q       <= '0;
      addr_q      <= '0;
      cpu_clk_q   <= 1'b0;
      cpu_clear_q <= 1'b1;
      mem_req_q   <= 1'b0;
      stopped_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      oneshot_q   <= oneshot_d;
      ins_q       <= ins_d;
      addr_q      <= addr_d;
      cpu_clk_q   <= !((state_d == S_CLEAR) || (state_d == S_EXEC_LO));
      cpu_clear_q <= (state_d == S_CLEAR);
      mem_req_q   <= (state_d == S_FETCH);
      stopped_q   <= (state_d == S_IDLE);
      halted_q    <= (state_d == S_HALT);
    end
  end

  // Counter advances on the EXEC_LO->EXEC_HI edge so steps rises with cpu_clk.
  step_counter #(.W(16)) u_steps (
    .clk   (clk),
    .clr_i (!_clear),
    .en_i  (state_q == S_EXEC_LO),
    .cnt_o (steps)
  );

  assign cpu_clk   = cpu_clk_q;
  assign cpu_clear = cpu_clear_q;
  assign cpu_ins   = ins_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = addr_q;
  assign stopped   = stopped_q;
  assign halted    = halted_q;

endmodule
